// File: rtl/alu_slice_sequencer_if.sv
// Request/response bundle for the nibble-serial ALU sequencer: two requesters
// in, one tagged response out.
interface alu_slice_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_zero;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zero,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zero,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_slice_sequencer.sv
// Shares one 4-bit AND/OR/XOR/ADD slice between two round-robin requesters,
// computing WIDTH-bit results one nibble per cycle, LSB nibble first.
module alu_slice_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_slice_sequencer_if.slave bus,
    output logic                 busy
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             last_nib;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result;
    logic [1:0]       op_q;
    logic             id_q;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [4:0]       nib_out;

    // {carry_out, sum}; only ADD can produce a carry.
    function automatic logic [4:0] slice_alu(input logic [1:0] op, input logic [3:0] a,
                                             input logic [3:0] b, input logic cin);
        logic [4:0] r;
        case (op)
            2'd0:    r = {1'b0, a & b};
            2'd1:    r = {1'b0, a | b};
            2'd2:    r = {1'b0, a ^ b};
            default: r = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        endcase
        return r;
    endfunction

    // ptr == 0 favours requester 0 when both are valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0 = ~ptr;
            grant1 = ptr;
        end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
        end
    end

    assign accept   = (state == IDLE) && (grant0 || grant1);
    assign last_nib = (idx == IDXW'(NIB - 1));
    assign nib_out  = slice_alu(op_q, a_q[{idx, 2'b00} +: 4], b_q[{idx, 2'b00} +: 4], carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_nib) state_nxt = DONE;
            DONE:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 2'd0;
            id_q   <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q    <= grant1 ? bus.req1_a : bus.req0_a;
                        b_q    <= grant1 ? bus.req1_b : bus.req0_b;
                        op_q   <= grant1 ? bus.req1_op : bus.req0_op;
                        id_q   <= grant1;
                        idx    <= '0;
                        carry  <= 1'b0;
                        result <= '0;
                        ptr    <= grant0;
                    end
                end
                RUN: begin
                    result[{idx, 2'b00} +: 4] <= nib_out[3:0];
                    carry                     <= nib_out[4];
                    if (!last_nib) idx <= idx + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

    // Ready is qualified by rst_n so every output reads 0 while reset is held.
    always_comb begin
        bus.req0_ready = rst_n && (state == IDLE) && grant0;
        bus.req1_ready = rst_n && (state == IDLE) && grant1;
        bus.rsp_valid  = (state == DONE);
        bus.rsp_id     = id_q;
        bus.rsp_result = result;
        bus.rsp_cout   = carry;
        bus.rsp_zero   = (state == DONE) && (result == '0);
        busy           = (state != IDLE);
    end
endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
- Shares one 4-bit bitwise/add ALU slice between two requesters.
- Computes WIDTH-bit operations nibble-serially: one nibble per cycle, LSB nibble first, with carry chained across nibbles for ADD.
- Sits between requesters and the 4-bit slice datapath. It handles arbitration, sequencing, carry state and the response handshake.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble beats per operation. Derived; not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready.
- req0_a  in  WIDTH  operand A, requester 0.
- req0_b  in  WIDTH  operand B, requester 0.
- req0_op  in  2  opcode, requester 0: 0 AND, 1 OR, 2 XOR, 3 ADD.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester that owns the result.
- rsp_result  out  WIDTH  operation result.
- rsp_cout  out  1  ADD carry-out of the MSB nibble; 0 for other ops.
- rsp_zero  out  1  rsp_result == 0. Carry is excluded.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE; all outputs 0; nibble index, carry, result and captured operands cleared; round-robin pointer favours requester 0. Any in-flight operation is discarded and no response is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE, arbitration:
  - grant = requester with valid; if both are valid, the one the pointer favours.
  - reqN_ready = (state==IDLE) & grantN. Ready is combinational from valid. At most one ready is high per cycle.
  - On handshake: capture a, b, op, id; idx=0; carry=0; result=0; pointer flips to favour the other requester; next state RUN.
  - No valid: stay IDLE and keep the pointer.
- RUN: each cycle computes nibble idx:
  - AND/OR/XOR: bitwise on a[4idx+3:4idx], b[...]; carry stays 0.
  - ADD: {c,s} = a_nib + b_nib + carry; carry<=c.
  - The result nibble idx is written at the clock edge.
  - idx==NIB-1 -> DONE; else idx+1.
- DONE:
  - rsp_valid=1; rsp_id, rsp_result, rsp_cout, rsp_zero are held stable until rsp_ready.
  - On rsp_valid&rsp_ready -> IDLE. No acceptance in the same cycle, since ready is only high in IDLE.
- Latency: handshake in cycle 0 -> rsp_valid high in cycle NIB+1 (cycle 5 for WIDTH=16).
- Throughput: one operation per NIB+2 cycles when rsp_ready is held high.
- Request inputs are ignored outside IDLE; requester operand changes after the handshake do not affect the result.
- rsp_valid deasserts in the cycle after the response handshake. rsp_result keeps its value until the next accept clears it.
- Simultaneous events:
  - Both requesters valid in IDLE: pointer decides.
  - A requester that drops valid before being granted loses nothing; no state is kept for it.
- Reset asserted in RUN or DONE returns to IDLE immediately (async) with all outputs at 0.

Test Plan:
- Reset, then req0 ADD a=0x00FF b=0x0001 -> req0_ready in cycle 0; rsp_valid in cycle 5; rsp_result=0x0100, cout=0, zero=0, id=0.
- req1 ADD a=0xFFFF b=0x0001 -> result=0x0000, cout=1, zero=1, id=1. Also verifies carry propagation through all 4 nibbles.
- Both valid continuously with rsp_ready=1, ops XOR a=0xA5A5 b=0xFFFF (req0) and AND a=0x1234 b=0x0F0F (req1):
  - Grants alternate 0,1,0,1.
  - Results 0x5A5A and 0x0204; cout=0.
  - Accepts spaced 6 cycles apart.
- rsp_ready held low 3 cycles in DONE -> rsp_valid and all rsp_* stay stable. No reqN_ready while pending; the new accept occurs only after the response handshake.
- Assert rst_n low during RUN idx=2 -> outputs 0 immediately; no response after release; the next request from req0 with req1 also valid is granted to req0.
- OR a=0x0000 b=0x0000 -> zero=1, cout=0. Then change req0_a mid-RUN to 0xFFFF -> result remains 0x0000.
